lvds_tx: RTL and testbench

- TX-side counterpart of the modem LVDS receive path.
- Pulls 32-bit I/Q words from the TX complex_fifo read port and serializes them 2 bits per clock.
- Its o_ddr_data[1:0] drives the DDR SB_IO output feeding o_iq_tx_p/n. The TX clock pair is forwarded separately.
- Word format: I sync 2'b10, I[12:0], ctrl bit, then Q sync 2'b01, Q[12:0], ctrl bit, MSB first.

---
 rtl/lvds_pkg.sv | 20 ++
 rtl/lvds_tx_if.sv | 27 ++
 rtl/lvds_tx.sv | 114 +++++++++++
 tb/tb_lvds_tx.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lvds_pkg.sv
// Shared LVDS constants, state encoding and sync-bit check used by the TX and RX paths.
package lvds_pkg;
  localparam int LVDS_WORD_BITS    = 32;
  localparam int LVDS_BITS_PER_CLK = 2;
  localparam int LVDS_CNT_W        = 4;

  localparam logic [1:0] LVDS_SYNC_I = 2'b10;
  localparam logic [1:0] LVDS_SYNC_Q = 2'b01;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    SHIFT = 2'd2
  } lvds_state_e;

  // I sync sits in the top two bits, Q sync in bits 15:14.
  function automatic logic lvds_sync_ok(input logic [LVDS_WORD_BITS-1:0] w);
    return (w[31:30] == LVDS_SYNC_I) && (w[15:14] == LVDS_SYNC_Q);
  endfunction
endpackage

// File: rtl/lvds_tx_if.sv
// FIFO read port, serial output and status of the LVDS TX serializer.
interface lvds_tx_if;
  import lvds_pkg::*;

  // Handshake: o_fifo_pull is a one-cycle read strobe, raised only after
  // i_tx_enable=1 and i_fifo_empty=0 were sampled; i_fifo_data is valid the
  // cycle after the strobe. No back-pressure exists on the serial side.
  logic                         i_tx_enable;
  logic                         i_fifo_empty;
  logic                         o_fifo_pull;
  logic [LVDS_WORD_BITS-1:0]    i_fifo_data;
  logic [LVDS_BITS_PER_CLK-1:0] o_ddr_data;
  logic                         o_tx_active;
  logic                         o_underrun;
  logic                         o_sync_error;
  lvds_state_e                  dbg_state;

  modport master (
    input  i_tx_enable, i_fifo_empty, i_fifo_data,
    output o_fifo_pull, o_ddr_data, o_tx_active, o_underrun, o_sync_error, dbg_state
  );

  modport slave (
    output i_tx_enable, i_fifo_empty, i_fifo_data,
    input  o_fifo_pull, o_ddr_data, o_tx_active, o_underrun, o_sync_error, dbg_state
  );
endinterface

// File: rtl/lvds_tx.sv
// Serializes 32-bit I/Q words from the TX FIFO two bits per clock, MSB first,
// with a prefetch so consecutive words stream back to back.
module lvds_tx
  import lvds_pkg::*;
#(
  parameter bit         CHECK_SYNC = 1'b1,
  parameter logic [1:0] IDLE_BITS  = 2'b00
) (
  input  logic      i_ddr_clk,
  input  logic      i_rst_b,
  lvds_tx_if.master bus
);
  // Pull strobe visible at counter 14 so the data is ready at counter 15.
  localparam logic [LVDS_CNT_W-1:0] CNT_PREFETCH = 4'd13;
  localparam logic [LVDS_CNT_W-1:0] CNT_UNDERRUN = 4'd14;
  localparam logic [LVDS_CNT_W-1:0] CNT_LAST     = 4'd15;

  lvds_state_e                  state_q, state_d;
  logic [LVDS_CNT_W-1:0]        cnt_q, cnt_d;
  logic [LVDS_WORD_BITS-1:0]    shift_q, shift_d;
  logic                         pend_q, pend_d;
  logic                         pull_q, pull_d;
  logic [LVDS_BITS_PER_CLK-1:0] ddr_q, ddr_d;
  logic                         active_q, active_d;
  logic                         underrun_q, underrun_d;
  logic                         sync_err_q, sync_err_d;

  logic                         sync_bad;
  logic [LVDS_WORD_BITS-1:0]    load_word;
  logic                         load_now;
  logic                         word_done;
  logic                         can_pull;

  always_comb begin
    sync_bad  = CHECK_SYNC && !lvds_sync_ok(bus.i_fifo_data);
    load_word = sync_bad ? '0 : bus.i_fifo_data;
    // pend_q marks a cycle in which the FIFO presents the word we pulled.
    load_now  = (state_q == FETCH) || ((state_q == SHIFT) && (cnt_q == CNT_LAST) && pend_q);
    word_done = (state_q == SHIFT) && (cnt_q == CNT_LAST) && !pend_q;
    can_pull  = bus.i_tx_enable && !bus.i_fifo_empty;
  end

  always_ff @(posedge i_ddr_clk or negedge i_rst_b) begin
    if (!i_rst_b) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      shift_q    <= '0;
      pend_q     <= 1'b0;
      pull_q     <= 1'b0;
      ddr_q      <= IDLE_BITS;
      active_q   <= 1'b0;
      underrun_q <= 1'b0;
      sync_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      shift_q    <= shift_d;
      pend_q     <= pend_d;
      pull_q     <= pull_d;
      ddr_q      <= ddr_d;
      active_q   <= active_d;
      underrun_q <= underrun_d;
      sync_err_q <= sync_err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (pull_q) state_d = FETCH;
      FETCH:   state_d = SHIFT;
      SHIFT:   if (word_done) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cnt_d      = cnt_q;
    shift_d    = shift_q;
    pend_d     = pull_q;
    pull_d     = 1'b0;
    ddr_d      = IDLE_BITS;
    active_d   = 1'b0;
    underrun_d = 1'b0;
    sync_err_d = 1'b0;

    if (load_now) begin
      ddr_d      = load_word[LVDS_WORD_BITS-1 -: LVDS_BITS_PER_CLK];
      shift_d    = {load_word[LVDS_WORD_BITS-LVDS_BITS_PER_CLK-1:0], {LVDS_BITS_PER_CLK{1'b0}}};
      cnt_d      = '0;
      active_d   = 1'b1;
      sync_err_d = sync_bad;
    end else if ((state_q == SHIFT) && (cnt_q != CNT_LAST)) begin
      ddr_d    = shift_q[LVDS_WORD_BITS-1 -: LVDS_BITS_PER_CLK];
      shift_d  = {shift_q[LVDS_WORD_BITS-LVDS_BITS_PER_CLK-1:0], {LVDS_BITS_PER_CLK{1'b0}}};
      cnt_d    = cnt_q + 1'b1;
      active_d = 1'b1;
    end

    if ((state_q == IDLE) && !pull_q && can_pull) pull_d = 1'b1;
    if ((state_q == SHIFT) && (cnt_q == CNT_PREFETCH) && can_pull) pull_d = 1'b1;

    // No prefetch went out while still enabled: the stream ends on an empty FIFO.
    if ((state_q == SHIFT) && (cnt_q == CNT_UNDERRUN) && !pull_q && bus.i_tx_enable)
      underrun_d = 1'b1;
  end

  assign bus.o_fifo_pull  = pull_q;
  assign bus.o_ddr_data   = ddr_q;
  assign bus.o_tx_active  = active_q;
  assign bus.o_underrun   = underrun_q;
  assign bus.o_sync_error = sync_err_q;
  assign bus.dbg_state    = state_q;
endmodule

// File: tb/tb_lvds_tx.sv
// Bench for lvds_tx: FIFO responder model, scoreboard of expected {sync_error, ddr_data}
// per cycle derived from each word handed to the DUT, and directed plus random scenarios.
module tb_lvds_tx;
  import lvds_pkg::*;

  localparam logic [1:0] IDLE_BITS = 2'b00;
  localparam int W = 3;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_b = 1'b0;
  always #5 clk = ~clk;

  lvds_tx_if bus_if();

  lvds_tx #(.CHECK_SYNC(1'b1), .IDLE_BITS(IDLE_BITS)) dut (
    .i_ddr_clk (clk),
    .i_rst_b   (rst_b),
    .bus       (bus_if.master)
  );

  // ---------------- scoreboard state ----------------
  int          n_cmp = 0;
  int          n_fail = 0;
  logic [W-1:0] exp_q[$];
  logic [31:0] fifo_q[$];
  int          pull_cyc_q[$];
  int          cyc = 0;
  int          pull_cnt = 0, underrun_cnt = 0, sync_cnt = 0, active_cnt = 0;
  int          run = 0, max_run = 0, last_pull_cyc = -100;
  logic        prev_active = 1'b0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic is_bad(input logic [31:0] w);
    return (w[31:30] != 2'b10) || (w[15:14] != 2'b01);
  endfunction

  function automatic logic [31:0] rand_valid();
    logic [31:0] r;
    r = $urandom();
    return {2'b10, r[13:0], 2'b01, r[29:16]};
  endfunction

  // A consumed word yields 16 pairs, MSB first; a bad word becomes zeros with the flag on pair 0.
  task automatic push_expected(input logic [31:0] w);
    logic [31:0] lw;
    logic        bad;
    logic [1:0]  p;
    bad = is_bad(w);
    lw  = bad ? 32'h0 : w;
    for (int k = 0; k < 16; k++) begin
      p = lw[31-2*k -: 2];
      exp_q.push_back({(k == 0) && bad, p});
    end
  endtask

  // ---------------- FIFO responder ----------------
  always @(posedge clk) begin
    logic [31:0] w;
    if (bus_if.o_fifo_pull === 1'b1) begin
      check("pull_fifo_nonempty", 64'(fifo_q.size() != 0), 1);
      if (fifo_q.size() != 0) begin
        w = fifo_q.pop_front();
        bus_if.i_fifo_data <= w;
        push_expected(w);
      end
    end
    bus_if.i_fifo_empty <= (fifo_q.size() == 0);
  end

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    logic [W-1:0] e;
    cyc++;
    if (bus_if.o_fifo_pull) begin
      pull_cnt++;
      last_pull_cyc = cyc;
      pull_cyc_q.push_back(cyc);
    end
    if (bus_if.o_tx_active) begin
      active_cnt++;
      run++;
      if (run > max_run) max_run = run;
      if (!prev_active) check("pull_to_first_bits", 64'(cyc - last_pull_cyc), 2);
      check("bits_pending", 64'(exp_q.size() != 0), 1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("ddr_sync", {bus_if.o_sync_error, bus_if.o_ddr_data}, e);
      end
      if (bus_if.o_underrun) check("underrun_on_last_pair", 64'(exp_q.size()), 0);
    end else begin
      run = 0;
      check("idle_out", {bus_if.o_sync_error, bus_if.o_ddr_data, bus_if.o_underrun},
            {1'b0, IDLE_BITS, 1'b0});
    end
    if (bus_if.o_sync_error) sync_cnt++;
    if (bus_if.o_underrun) underrun_cnt++;
    prev_active = bus_if.o_tx_active;
  end

  // ---------------- driver tasks ----------------
  task automatic clear_stats();
    pull_cnt = 0; underrun_cnt = 0; sync_cnt = 0; active_cnt = 0; max_run = 0;
    pull_cyc_q.delete();
  endtask

  task automatic do_reset(input bit clear_fifo);
    @(negedge clk); #1;
    rst_b = 1'b0;
    exp_q.delete();
    if (clear_fifo) fifo_q.delete();
    repeat (3) @(negedge clk);
    #1 rst_b = 1'b1;
  endtask

  task automatic wait_active(input int maxc, input string nm);
    bit seen = 1'b0;
    for (int i = 0; i < maxc && !seen; i++) begin
      @(negedge clk);
      seen = bus_if.o_tx_active;
    end
    check(nm, seen, 1);
    #1;
  endtask

  task automatic wait_idle(input int maxc, input string nm);
    bit seen = 1'b0;
    for (int i = 0; i < maxc && !seen; i++) begin
      @(negedge clk);
      seen = !bus_if.o_tx_active && !bus_if.o_fifo_pull && (bus_if.dbg_state == IDLE);
    end
    check(nm, seen, 1);
    #1;
  endtask

  task automatic load_words(input logic [31:0] w0, input logic [31:0] w1, input int n);
    bus_if.i_tx_enable = 1'b0;
    if (n > 0) fifo_q.push_back(w0);
    if (n > 1) fifo_q.push_back(w1);
  endtask

  task automatic start_stream();
    repeat (2) @(negedge clk);
    #1;
    clear_stats();
    bus_if.i_tx_enable = 1'b1;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int n, nbad;
    logic [31:0] w;
    bus_if.i_tx_enable = 1'b0;

    // reset values
    repeat (3) @(negedge clk);
    #1;
    check("rst_pull",     bus_if.o_fifo_pull, 0);
    check("rst_ddr",      bus_if.o_ddr_data, IDLE_BITS);
    check("rst_active",   bus_if.o_tx_active, 0);
    check("rst_underrun", bus_if.o_underrun, 0);
    check("rst_sync",     bus_if.o_sync_error, 0);
    check("rst_state",    bus_if.dbg_state, IDLE);
    rst_b = 1'b1;

    // single word
    load_words(32'h8000_4000, 32'h0, 1);
    start_stream();
    wait_active(20, "t1_start");
    wait_idle(40, "t1_end");
    check("t1_pulls", pull_cnt, 1);
    check("t1_underrun", underrun_cnt, 1);
    check("t1_active", active_cnt, 16);
    check("t1_sync", sync_cnt, 0);

    // four-word stream
    load_words(32'hBFFE_7FFE, 32'h8002_4002, 2);
    fifo_q.push_back(rand_valid());
    fifo_q.push_back(rand_valid());
    start_stream();
    wait_active(20, "t2_start");
    wait_idle(120, "t2_end");
    check("t2_pulls", pull_cnt, 4);
    check("t2_contiguous", max_run, 64);
    check("t2_active", active_cnt, 64);
    check("t2_underrun", underrun_cnt, 1);
    for (int i = 1; i < pull_cyc_q.size(); i++)
      check("t2_pull_spacing", 64'(pull_cyc_q[i] - pull_cyc_q[i-1]), 16);

    // enable dropped at pair 5
    load_words(rand_valid(), rand_valid(), 2);
    start_stream();
    wait_active(20, "t3_start");
    repeat (5) @(negedge clk);
    #1 bus_if.i_tx_enable = 1'b0;
    wait_idle(40, "t3_end");
    repeat (5) @(negedge clk);
    #1;
    check("t3_pulls", pull_cnt, 1);
    check("t3_underrun", underrun_cnt, 0);
    check("t3_active", active_cnt, 16);
    check("t3_fifo_left", 64'(fifo_q.size()), 1);
    do_reset(1'b1);

    // sync error then a valid word
    load_words(32'h0000_0000, 32'h8000_4000, 2);
    start_stream();
    wait_active(20, "t4_start");
    wait_idle(60, "t4_end");
    check("t4_sync_pulses", sync_cnt, 1);
    check("t4_contiguous", max_run, 32);
    check("t4_pulls", pull_cnt, 2);

    // asynchronous reset at pair 8
    load_words(rand_valid(), rand_valid(), 2);
    start_stream();
    wait_active(20, "t5_start");
    repeat (8) @(negedge clk);
    #1 rst_b = 1'b0;
    #1;
    check("t5_async_active", bus_if.o_tx_active, 0);
    check("t5_async_ddr",    bus_if.o_ddr_data, IDLE_BITS);
    check("t5_async_pull",   bus_if.o_fifo_pull, 0);
    check("t5_async_state",  bus_if.dbg_state, IDLE);
    exp_q.delete();
    clear_stats();
    repeat (2) @(negedge clk);
    #1 rst_b = 1'b1;
    wait_active(20, "t5_restart");
    wait_idle(40, "t5_end");
    check("t5_pulls", pull_cnt, 1);
    check("t5_active", active_cnt, 16);
    check("t5_underrun", underrun_cnt, 1);

    // enabled with empty FIFO
    bus_if.i_tx_enable = 1'b0;
    start_stream();
    repeat (100) @(negedge clk);
    #1;
    check("t6_pulls", pull_cnt, 0);
    check("t6_active", active_cnt, 0);

    // randomized bursts, some with corrupted sync bits
    for (int r = 0; r < 6; r++) begin
      bus_if.i_tx_enable = 1'b0;
      n = $urandom_range(1, 5);
      nbad = 0;
      for (int k = 0; k < n; k++) begin
        w = ($urandom_range(0, 3) == 0) ? $urandom() : rand_valid();
        if (is_bad(w)) nbad++;
        fifo_q.push_back(w);
      end
      start_stream();
      wait_active(20, "rnd_start");
      wait_idle(16 * n + 40, "rnd_end");
      check("rnd_pulls", pull_cnt, n);
      check("rnd_contiguous", max_run, 16 * n);
      check("rnd_sync", sync_cnt, nbad);
      check("rnd_underrun", underrun_cnt, 1);
    end

    bus_if.i_tx_enable = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("exp_drained", 64'(exp_q.size()), 0);

    // ---------------- report ----------------
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
    $fatal(1, "watchdog expired");
  end
endmodule
